uart_msg_formatter: RTL and testbench

Parametrised successor to the single-format time-string sender. It captures a coherent snapshot of packed BCD digits on `start` and formats it as a mode-selected ASCII line: header, digit fields, separators, terminator. The line is fed one byte at a time to the UART transmitter using a full busy-rise/busy-fall handshake, with a timeout. It sits between the watch datapath (time/date/alarm/stopwatch counters) and `uart_tx`.

---
 rtl/uart_msg_formatter.sv | 167 ++++++++++++++++
 tb/tb_uart_msg_formatter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_formatter.sv
// Formats a captured BCD snapshot into a mode-selected ASCII line and feeds it
// byte-by-byte to uart_tx using a busy-rise/busy-fall handshake with a timeout.
module uart_msg_formatter #(
   parameter int NUM_FIELDS = 4,
   parameter int DIGITS     = 2,
   parameter int CRLF       = 0,
   parameter int ACK_WAIT   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [1:0]                     mode,
   input  logic [4*NUM_FIELDS*DIGITS-1:0] bcd_in,
   input  logic                           tx_busy,
   output logic                           send_start,
   output logic [7:0]                     ascii_data,
   output logic                           busy,
   output logic                           done
);

   localparam int ND       = NUM_FIELDS * DIGITS;
   localparam int MSG_LEN  = 7 + ND + (NUM_FIELDS - 1) + 1 + CRLF;
   localparam int BODY_END = 7 + ND + (NUM_FIELDS - 1);
   localparam int IW       = $clog2(MSG_LEN);
   localparam int CW       = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_STROBE  = 2'd1;
   localparam logic [1:0] S_WAIT_HI = 2'd2;
   localparam logic [1:0] S_WAIT_LO = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      mode_q, mode_d;
   logic [4*ND-1:0] bcd_q, bcd_d;
   logic [7:0]      data_q, data_d;
   logic            strobe_q, strobe_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [IW-1:0]   idx_next;
   logic [7:0]      msg_byte [MSG_LEN];

   function automatic logic [7:0] header_char(input logic [1:0] m, input int pos);
      logic [55:0] hdr;
      case (m)
         2'd0:    hdr = "TIME = ";
         2'd1:    hdr = "DATE = ";
         2'd2:    hdr = "ALRM = ";
         default: hdr = "STPW = ";
      endcase
      return hdr[8*(6-pos) +: 8];
   endfunction

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
   endfunction

   // Each byte position is bound at elaboration to a header char, a digit,
   // a separator or the terminator, so the runtime mux is just msg_byte[idx].
   genvar gi;
   generate
      for (gi = 0; gi < MSG_LEN; gi++) begin : g_byte
         if (gi < 7) begin : g_hdr
            assign msg_byte[gi] = header_char(mode_q, gi);
         end else if (gi < BODY_END) begin : g_body
            localparam int P = gi - 7;
            localparam int O = P % (DIGITS + 1);
            if (O == DIGITS) begin : g_sep
               assign msg_byte[gi] = (mode_q == 2'd1) ? 8'h2D : 8'h3A;
            end else begin : g_dig
               localparam int K = ND - 1 - ((P / (DIGITS + 1)) * DIGITS + O);
               assign msg_byte[gi] = digit_char(bcd_q[4*K +: 4]);
            end
         end else if (CRLF != 0 && gi == BODY_END) begin : g_cr
            assign msg_byte[gi] = 8'h0D;
         end else begin : g_lf
            assign msg_byte[gi] = 8'h0A;
         end
      end
   endgenerate

   assign idx_next = idx_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      bcd_d    = bcd_q;
      data_d   = data_q;
      strobe_d = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Byte 0 comes from the live mode since the snapshot loads this edge.
            if (start) begin
               mode_d   = mode;
               bcd_d    = bcd_in;
               idx_d    = '0;
               data_d   = header_char(mode, 0);
               strobe_d = 1'b1;
               busy_d   = 1'b1;
               state_d  = S_STROBE;
            end
         end
         S_STROBE: begin
            cnt_d   = '0;
            state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            // A missed busy rise falls through WAIT_LO, which then sees busy low.
            if (tx_busy || cnt_q == CW'(ACK_WAIT - 1)) begin
               state_d = S_WAIT_LO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) begin
               if (idx_q == IW'(MSG_LEN - 1)) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d    = idx_next;
                  data_d   = msg_byte[idx_next];
                  strobe_d = 1'b1;
                  state_d  = S_STROBE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         mode_q   <= '0;
         bcd_q    <= '0;
         data_q   <= 8'h00;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         bcd_q    <= bcd_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign send_start = strobe_q;
   assign ascii_data = data_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_uart_msg_formatter.sv
// Scoreboard bench: stimulus pushes expected bytes (and a -1 end-of-line marker),
// monitors pop and compare on each send_start / done of the two DUT instances.
module tb_uart_msg_formatter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, start2;
   logic [1:0]  mode, mode2;
   logic [31:0] bcd_in;
   logic [23:0] bcd2;
   logic        tx_busy, tx_busy2;
   logic        send_start, busy, done, send_start2, busy2, done2;
   logic [7:0]  ascii_data, ascii_data2;

   uart_msg_formatter dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .bcd_in(bcd_in),
      .tx_busy(tx_busy), .send_start(send_start), .ascii_data(ascii_data),
      .busy(busy), .done(done)
   );

   uart_msg_formatter #(.NUM_FIELDS(3), .DIGITS(2), .CRLF(1), .ACK_WAIT(4)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(mode2), .bcd_in(bcd2),
      .tx_busy(tx_busy2), .send_start(send_start2), .ascii_data(ascii_data2),
      .busy(busy2), .done(done2)
   );

   // Transmitter models: busy rises the cycle after a strobe and lasts B cycles.
   int   tx_cnt = 0, tx_cnt2 = 0;
   logic tx_en = 1'b1;
   always @(posedge clk) begin
      if (rst) tx_cnt <= 0;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
      else if (send_start && tx_en) tx_cnt <= 10;
      if (rst) tx_cnt2 <= 0;
      else if (tx_cnt2 != 0) tx_cnt2 <= tx_cnt2 - 1;
      else if (send_start2) tx_cnt2 <= 3;
   end
   assign tx_busy  = (tx_cnt != 0);
   assign tx_busy2 = (tx_cnt2 != 0);

   int tests = 0, fails = 0;
   int exp_q[$], exp_q2[$];
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push_line(input int which, input string s, input bit crlf);
      for (int i = 0; i < s.len(); i++) begin
         if (which == 0) exp_q.push_back(int'(s[i])); else exp_q2.push_back(int'(s[i]));
      end
      if (crlf) begin
         if (which == 0) exp_q.push_back(13); else exp_q2.push_back(13);
      end
      if (which == 0) begin exp_q.push_back(10); exp_q.push_back(-1); end
      else begin exp_q2.push_back(10); exp_q2.push_back(-1); end
   endtask

   task automatic push_prefix(input string s, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(int'(s[i]));
   endtask

   // Monitor state for the default instance
   int   line_pos = 0, last_strobe = 0, done_cyc = -10, done_cnt = 0, done_cnt2 = 0;
   logic prev_strobe = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, prev_strobe2 = 1'b0;
   bit   timeout_mode = 1'b0, b2b_check = 1'b0;

   always @(negedge clk) begin : mon
      int e;
      if (rst) begin
         line_pos = 0; prev_strobe = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
         prev_strobe2 = 1'b0;
      end else begin
         if (send_start) begin
            check("strobe_single", int'(prev_strobe), 0);
            if (timeout_mode && line_pos > 0) check("timeout_spacing", cyc - last_strobe, 6);
            if (b2b_check && line_pos == 0) begin
               check("b2b_latency", cyc - done_cyc, 1);
               b2b_check = 1'b0;
            end
            if (exp_q.size() != 0) e = exp_q.pop_front(); else e = -2;
            $display("[TB] dut0 byte %0d tx 0x%02h exp 0x%0h", line_pos, ascii_data, e);
            check("byte", int'(ascii_data), e);
            last_strobe = cyc;
            line_pos++;
         end
         if (done) begin
            check("done_single", int'(prev_done), 0);
            check("busy_fall_with_done", int'(busy), 0);
            check("busy_before_done", int'(prev_busy), 1);
            if (exp_q.size() != 0) e = exp_q.pop_front(); else e = -2;
            $display("[TB] dut0 done after %0d bytes", line_pos);
            check("line_end", -1, e);
            done_cyc = cyc;
            done_cnt++;
            line_pos = 0;
         end
         if (send_start2) begin
            check("strobe_single2", int'(prev_strobe2), 0);
            if (exp_q2.size() != 0) e = exp_q2.pop_front(); else e = -2;
            $display("[TB] dut2 tx 0x%02h exp 0x%0h", ascii_data2, e);
            check("byte2", int'(ascii_data2), e);
         end
         if (done2) begin
            if (exp_q2.size() != 0) e = exp_q2.pop_front(); else e = -2;
            $display("[TB] dut2 done");
            check("line_end2", -1, e);
            check("busy_fall_with_done2", int'(busy2), 0);
            done_cnt2++;
         end
         prev_strobe  = send_start;
         prev_busy    = busy;
         prev_done    = done;
         prev_strobe2 = send_start2;
      end
   end

   task automatic wait_pos(input int target, input int budget);
      int n = 0;
      while (line_pos < target && n < budget) begin @(negedge clk); n++; end
      check("wait_strobes", (line_pos >= target) ? 1 : 0, 1);
   endtask

   task automatic wait_done(input int which, input int target, input int budget);
      int n = 0;
      while (((which == 0) ? done_cnt : done_cnt2) < target && n < budget) begin
         @(negedge clk); n++;
      end
      check("wait_done", (which == 0) ? done_cnt : done_cnt2, target);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'd0; bcd_in = '0;
      start2 = 1'b0; mode2 = 2'd0; bcd2 = '0;
      repeat (3) @(negedge clk);
      check("rst_send_start", int'(send_start), 0);
      check("rst_ascii", int'(ascii_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst = 1'b0;

      // Default line, snapshot coherency, ignored mid-line start, back-to-back line
      push_line(0, "TIME = 12:34:56:78", 1'b0);
      push_line(0, "STPW = 99:99:99:99", 1'b0);
      mode = 2'd0; bcd_in = 32'h12345678; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_pos(3, 200);
      mode = 2'd3; bcd_in = 32'h99999999;
      wait_pos(8, 400);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_pos(17, 400);
      start = 1'b1; b2b_check = 1'b1;
      wait_done(0, 1, 400);
      wait_pos(1, 50);
      start = 1'b0;
      wait_done(0, 2, 500);

      // Date format on the 3x2 CRLF instance
      push_line(1, "DATE = 25-07-1?", 1'b1);
      mode2 = 2'd1; bcd2 = 24'h25071A; start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      wait_done(1, 1, 500);
      check("hold_terminator2", int'(ascii_data2), 8'h0A);

      // Timeout path: transmitter never raises busy
      tx_en = 1'b0; timeout_mode = 1'b1;
      push_line(0, "ALRM = 09:11:23:59", 1'b0);
      mode = 2'd2; bcd_in = 32'h09112359; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(0, 3, 400);
      timeout_mode = 1'b0; tx_en = 1'b1;
      check("hold_terminator", int'(ascii_data), 8'h0A);

      // Reset during byte 5, then a fresh full line
      push_prefix("TIME = ", 6);
      mode = 2'd0; bcd_in = 32'h12345678; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_pos(6, 200);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      check("midrst_send_start", int'(send_start), 0);
      check("midrst_ascii", int'(ascii_data), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_prefix_sent", exp_q.size(), 0);
      repeat (40) @(negedge clk);
      push_line(0, "TIME = 12:34:56:78", 1'b0);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_done(0, 4, 500);

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      check("queue_empty2", exp_q2.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
